// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//   Shared defines and package for the architectural register file.
//
//   Shared defines (kept here so every file of the slice sees one copy):
//     ROB_WIDTH  width of a ROB entry id
//     ROB_SIZE   number of ROB entries
//     REG_X0     register id of the hardwired-zero register
//
//   Package contents:
//     REGFILE_ROB_W   ROB tag width seen by the register file
//     REGFILE_NREG    number of architectural registers
//     REG_X0_ID       typed copy of REG_X0
//     operand_src_e   where a resolved source operand comes from
// ---------------------------------------------------------------------------
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif

`ifndef ROB_SIZE
`define ROB_SIZE 16
`endif

`ifndef REG_X0
`define REG_X0 5'd0
`endif

package regfile_pkg;

  localparam int REGFILE_ROB_W = `ROB_WIDTH;
  localparam int REGFILE_NREG  = 32;

  localparam logic [4:0] REG_X0_ID = `REG_X0;

  // Source of an operand as seen by the decoder
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_REG  = 2'd1,
    SRC_FWD  = 2'd2,
    SRC_DEP  = 2'd3
  } operand_src_e;

endpackage

// File: rtl/regfile_rd_port.sv
// ---------------------------------------------------------------------------
// regfile_rd_port
//   Combinational resolve of one decoder source operand. Picks between the
//   hardwired zero, the architectural value, a value forwarded from the ROB
//   search port, or a pending dependency on a ROB tag.
//
//   Ports:
//     rs            source register id
//     reg_busy      busy bit of that register
//     reg_val       architectural value of that register
//     reg_tag       ROB tag that will produce its next value
//     search_ready  ROB already holds the value for reg_tag
//     search_val    that value
//     val           resolved operand value (0 while pending)
//     dep_valid     operand is still pending
//     dep           ROB tag the operand waits on
// ---------------------------------------------------------------------------
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int ROB_W = REGFILE_ROB_W
) (
  input  logic [4:0]       rs,
  input  logic             reg_busy,
  input  logic [31:0]      reg_val,
  input  logic [ROB_W-1:0] reg_tag,
  input  logic             search_ready,
  input  logic [31:0]      search_val,
  output logic [31:0]      val,
  output logic             dep_valid,
  output logic [ROB_W-1:0] dep
);

  operand_src_e src;

  // Priority: x0 first, then an idle register, then a ROB forward; only if
  // none of those apply does the operand wait on the producer tag.
  always_comb begin
    src = SRC_DEP;
    if (rs == REG_X0_ID) begin
      src = SRC_ZERO;
    end else if (!reg_busy) begin
      src = SRC_REG;
    end else if (search_ready) begin
      src = SRC_FWD;
    end
  end

  always_comb begin
    val       = 32'd0;
    dep_valid = 1'b0;
    case (src)
      SRC_ZERO: val = 32'd0;
      SRC_REG:  val = reg_val;
      SRC_FWD:  val = search_val;
      SRC_DEP:  dep_valid = 1'b1;
      default:  val = 32'd0;
    endcase
  end

  // The tag is only meaningful while dep_valid is high
  assign dep = reg_tag;

endmodule

// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile
//   Architectural register file with renaming tags for the out-of-order core.
//   Each register carries a value, a busy bit and the ROB tag of its youngest
//   in-flight producer. Decoder operands resolve combinationally against the
//   pre-edge state; ROB commits update values at the clock edge.
//
//   Optional feature (macro REGFILE_BUSY_COUNT_EN): adds a registered
//   busy_count output holding the number of busy registers.
//
//   Ports:
//     clk_in, rst_in, rdy_in     clock, sync active-high reset, global stall
//     clear                      mispredict flush (drops all busy bits)
//     dec_ready/dec_rd/dec_rob_id  rename of an issued instruction
//     dec_rs1/dec_rs2            decoder source registers
//     val1/dep1_valid/dep1       resolved operand 1
//     val2/dep2_valid/dep2       resolved operand 2
//     search_rob_id_k/search_ready_k/search_val_k  ROB search port k
//     commit_ready/commit_rob_id/commit_reg_id/commit_val  ROB commit
//     busy_count                 (optional) number of busy registers
// ---------------------------------------------------------------------------
module regfile
  import regfile_pkg::*;
#(
  parameter int ROB_W = REGFILE_ROB_W,
  parameter int NREG  = REGFILE_NREG
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear,
  input  logic             dec_ready,
  input  logic [4:0]       dec_rd,
  input  logic [ROB_W-1:0] dec_rob_id,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  output logic [31:0]      val1,
  output logic             dep1_valid,
  output logic [ROB_W-1:0] dep1,
  output logic [31:0]      val2,
  output logic             dep2_valid,
  output logic [ROB_W-1:0] dep2,
  output logic [ROB_W-1:0] search_rob_id_1,
  input  logic             search_ready_1,
  input  logic [31:0]      search_val_1,
  output logic [ROB_W-1:0] search_rob_id_2,
  input  logic             search_ready_2,
  input  logic [31:0]      search_val_2,
  input  logic             commit_ready,
  input  logic [ROB_W-1:0] commit_rob_id,
  input  logic [4:0]       commit_reg_id,
  input  logic [31:0]      commit_val
`ifdef REGFILE_BUSY_COUNT_EN
  ,
  output logic [5:0]       busy_count
`endif
);

  logic [31:0]      val_q [NREG];
  logic [ROB_W-1:0] tag_q [NREG];
  logic [NREG-1:0]  busy_q;

  logic [31:0]      val_n [NREG];
  logic [ROB_W-1:0] tag_n [NREG];
  logic [NREG-1:0]  busy_n;

  // Read path: both operands see the state before this edge, so an
  // instruction whose rs equals its rd never observes its own rename.
  assign search_rob_id_1 = tag_q[dec_rs1];
  assign search_rob_id_2 = tag_q[dec_rs2];

  regfile_rd_port #(.ROB_W(ROB_W)) u_rd_port_1 (
    .rs           (dec_rs1),
    .reg_busy     (busy_q[dec_rs1]),
    .reg_val      (val_q[dec_rs1]),
    .reg_tag      (tag_q[dec_rs1]),
    .search_ready (search_ready_1),
    .search_val   (search_val_1),
    .val          (val1),
    .dep_valid    (dep1_valid),
    .dep          (dep1)
  );

  regfile_rd_port #(.ROB_W(ROB_W)) u_rd_port_2 (
    .rs           (dec_rs2),
    .reg_busy     (busy_q[dec_rs2]),
    .reg_val      (val_q[dec_rs2]),
    .reg_tag      (tag_q[dec_rs2]),
    .search_ready (search_ready_2),
    .search_val   (search_val_2),
    .val          (val2),
    .dep_valid    (dep2_valid),
    .dep          (dep2)
  );

  // Next-state: commit first, then issue/clear. Ordering makes an issue to
  // the same register override the commit's busy release, while the commit
  // value still lands. A commit whose tag is stale (a younger producer owns
  // the register) only updates the value.
  always_comb begin
    val_n  = val_q;
    tag_n  = tag_q;
    busy_n = busy_q;

    if (commit_ready && commit_reg_id != REG_X0_ID) begin
      val_n[commit_reg_id] = commit_val;
      if (busy_q[commit_reg_id] && tag_q[commit_reg_id] == commit_rob_id) begin
        busy_n[commit_reg_id] = 1'b0;
      end
    end

    if (clear) begin
      busy_n = '0;
    end else if (dec_ready && dec_rd != REG_X0_ID) begin
      busy_n[dec_rd] = 1'b1;
      tag_n[dec_rd]  = dec_rob_id;
    end
  end

  // State update; reset wins over the global stall
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NREG; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
      busy_q <= '0;
    end else if (rdy_in) begin
      val_q  <= val_n;
      tag_q  <= tag_n;
      busy_q <= busy_n;
    end
  end

`ifdef REGFILE_BUSY_COUNT_EN
  logic [5:0] busy_count_n;

  // Population count of the next-state busy vector
  always_comb begin
    busy_count_n = '0;
    for (int i = 0; i < NREG; i++) begin
      busy_count_n = busy_count_n + 6'(busy_n[i]);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_count <= '0;
    end else if (rdy_in) begin
      busy_count <= busy_count_n;
    end
  end
`endif

endmodule

// File: tb/tb_regfile.sv
// ---------------------------------------------------------------------------
// tb_regfile
//   Directed vector bench for regfile. Each vector drives decoder, commit
//   and search inputs after a falling edge, checks the combinational read
//   outputs (pre-edge state), then lets the rising edge update state.
// ---------------------------------------------------------------------------
module tb_regfile;
  import regfile_pkg::*;

  localparam int RW = REGFILE_ROB_W;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          clear;
  logic          dec_ready;
  logic [4:0]    dec_rd;
  logic [RW-1:0] dec_rob_id;
  logic [4:0]    dec_rs1;
  logic [4:0]    dec_rs2;
  logic [31:0]   val1;
  logic          dep1_valid;
  logic [RW-1:0] dep1;
  logic [31:0]   val2;
  logic          dep2_valid;
  logic [RW-1:0] dep2;
  logic [RW-1:0] search_rob_id_1;
  logic          search_ready_1;
  logic [31:0]   search_val_1;
  logic [RW-1:0] search_rob_id_2;
  logic          search_ready_2;
  logic [31:0]   search_val_2;
  logic          commit_ready;
  logic [RW-1:0] commit_rob_id;
  logic [4:0]    commit_reg_id;
  logic [31:0]   commit_val;
`ifdef REGFILE_BUSY_COUNT_EN
  logic [5:0]    busy_count;
`endif

  regfile dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .clear           (clear),
    .dec_ready       (dec_ready),
    .dec_rd          (dec_rd),
    .dec_rob_id      (dec_rob_id),
    .dec_rs1         (dec_rs1),
    .dec_rs2         (dec_rs2),
    .val1            (val1),
    .dep1_valid      (dep1_valid),
    .dep1            (dep1),
    .val2            (val2),
    .dep2_valid      (dep2_valid),
    .dep2            (dep2),
    .search_rob_id_1 (search_rob_id_1),
    .search_ready_1  (search_ready_1),
    .search_val_1    (search_val_1),
    .search_rob_id_2 (search_rob_id_2),
    .search_ready_2  (search_ready_2),
    .search_val_2    (search_val_2),
    .commit_ready    (commit_ready),
    .commit_rob_id   (commit_rob_id),
    .commit_reg_id   (commit_reg_id),
    .commit_val      (commit_val)
`ifdef REGFILE_BUSY_COUNT_EN
    ,
    .busy_count      (busy_count)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int issue, rd, rob;
    int commit, creg, crob, cval;
    int clr, rdy;
    int rs1, rs2;
    int sr1, sv1, sr2, sv2;
    int e_val1, e_dv1, e_dep1;
    int e_val2, e_dv2, e_dep2;
    int chk_sid, e_sid1;
  } vec_t;

  int errors = 0;
  int checks = 0;
  vec_t vecs[22];

  function automatic vec_t vec(
    int issue, int rd, int rob,
    int commit, int creg, int crob, int cval,
    int clr, int rdy, int rs1, int rs2,
    int sr1, int sv1, int sr2, int sv2,
    int e_val1, int e_dv1, int e_dep1,
    int e_val2, int e_dv2, int e_dep2,
    int chk_sid, int e_sid1);
    vec_t v;
    v.issue = issue; v.rd = rd; v.rob = rob;
    v.commit = commit; v.creg = creg; v.crob = crob; v.cval = cval;
    v.clr = clr; v.rdy = rdy; v.rs1 = rs1; v.rs2 = rs2;
    v.sr1 = sr1; v.sv1 = sv1; v.sr2 = sr2; v.sv2 = sv2;
    v.e_val1 = e_val1; v.e_dv1 = e_dv1; v.e_dep1 = e_dep1;
    v.e_val2 = e_val2; v.e_dv2 = e_dv2; v.e_dep2 = e_dep2;
    v.chk_sid = chk_sid; v.e_sid1 = e_sid1;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    clear = 0; dec_ready = 0; dec_rd = 0; dec_rob_id = '0;
    dec_rs1 = 0; dec_rs2 = 0;
    search_ready_1 = 0; search_val_1 = 0; search_ready_2 = 0; search_val_2 = 0;
    commit_ready = 0; commit_rob_id = '0; commit_reg_id = 0; commit_val = 0;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    @(negedge clk_in);
    dec_ready      = v.issue[0];
    dec_rd         = 5'(v.rd);
    dec_rob_id     = RW'(v.rob);
    commit_ready   = v.commit[0];
    commit_reg_id  = 5'(v.creg);
    commit_rob_id  = RW'(v.crob);
    commit_val     = 32'(v.cval);
    clear          = v.clr[0];
    rdy_in         = v.rdy[0];
    dec_rs1        = 5'(v.rs1);
    dec_rs2        = 5'(v.rs2);
    search_ready_1 = v.sr1[0];
    search_val_1   = 32'(v.sv1);
    search_ready_2 = v.sr2[0];
    search_val_2   = 32'(v.sv2);
    #1;
    tag = $sformatf("v%0d", idx);
    checkOutput({tag, ".val1"}, val1, 32'(v.e_val1));
    checkOutput({tag, ".dep1_valid"}, 32'(dep1_valid), 32'(v.e_dv1));
    if (v.e_dv1 != 0) checkOutput({tag, ".dep1"}, 32'(dep1), 32'(v.e_dep1));
    checkOutput({tag, ".val2"}, val2, 32'(v.e_val2));
    checkOutput({tag, ".dep2_valid"}, 32'(dep2_valid), 32'(v.e_dv2));
    if (v.e_dv2 != 0) checkOutput({tag, ".dep2"}, 32'(dep2), 32'(v.e_dep2));
    if (v.chk_sid != 0) checkOutput({tag, ".search_rob_id_1"}, 32'(search_rob_id_1), 32'(v.e_sid1));
  endtask

  initial begin
    // issue rd rob | commit creg crob cval | clr rdy | rs1 rs2 | sr1 sv1 sr2 sv2 | exp1 | exp2 | sid
    vecs[0]  = vec(0,0,0,   0,0,0,0,         0,1, 5,0, 0,0,0,0,        0,0,0,       0,0,0,    1,0);
    vecs[1]  = vec(1,5,3,   0,0,0,0,         0,1, 5,0, 0,0,0,0,        0,0,0,       0,0,0,    1,0);
    vecs[2]  = vec(0,0,0,   0,0,0,0,         0,1, 5,0, 0,0,0,0,        0,1,3,       0,0,0,    1,3);
    vecs[3]  = vec(0,0,0,   0,0,0,0,         0,1, 5,0, 1,'hAB,0,0,     'hAB,0,0,    0,0,0,    1,3);
    vecs[4]  = vec(1,5,7,   0,0,0,0,         0,1, 5,0, 0,0,0,0,        0,1,3,       0,0,0,    1,3);
    vecs[5]  = vec(0,0,0,   1,5,3,'h11,      0,1, 5,5, 0,0,1,'h99,     0,1,7,       'h99,0,0, 1,7);
    vecs[6]  = vec(0,0,0,   1,5,7,'h22,      0,1, 5,0, 0,0,0,0,        0,1,7,       0,0,0,    1,7);
    vecs[7]  = vec(0,0,0,   0,0,0,0,         0,1, 5,0, 0,0,0,0,        'h22,0,0,    0,0,0,    1,7);
    vecs[8]  = vec(1,6,2,   0,0,0,0,         0,1, 0,0, 0,0,0,0,        0,0,0,       0,0,0,    1,0);
    vecs[9]  = vec(1,6,4,   1,6,2,'h55,      0,1, 6,0, 0,0,0,0,        0,1,2,       0,0,0,    1,2);
    vecs[10] = vec(0,0,0,   0,0,0,0,         0,1, 6,0, 0,0,0,0,        0,1,4,       0,0,0,    1,4);
    vecs[11] = vec(0,0,0,   1,2,0,'h1234,    0,1, 2,0, 0,0,0,0,        0,0,0,       0,0,0,    1,0);
    vecs[12] = vec(1,1,8,   0,0,0,0,         0,1, 2,0, 0,0,0,0,        'h1234,0,0,  0,0,0,    1,0);
    vecs[13] = vec(1,2,9,   0,0,0,0,         0,1, 1,0, 0,0,0,0,        0,1,8,       0,0,0,    1,8);
    vecs[14] = vec(1,3,10,  0,0,0,0,         0,1, 1,2, 0,0,0,0,        0,1,8,       0,1,9,    1,8);
    vecs[15] = vec(1,9,5,   1,4,0,'h44,      1,1, 3,6, 0,0,0,0,        0,1,10,      0,1,4,    1,10);
    vecs[16] = vec(0,0,0,   0,0,0,0,         0,1, 2,6, 0,0,0,0,        'h1234,0,0,  'h55,0,0, 0,0);
    vecs[17] = vec(0,0,0,   0,0,0,0,         0,1, 9,3, 0,0,0,0,        0,0,0,       0,0,0,    0,0);
    vecs[18] = vec(0,0,0,   1,0,0,'hFFFF,    0,1, 4,0, 0,0,0,0,        'h44,0,0,    0,0,0,    0,0);
    vecs[19] = vec(1,8,6,   1,5,0,'hDEAD,    0,0, 0,0, 0,0,0,0,        0,0,0,       0,0,0,    0,0);
    vecs[20] = vec(0,0,0,   0,0,0,0,         0,1, 8,5, 0,0,0,0,        0,0,0,       'h22,0,0, 0,0);
    vecs[21] = vec(0,0,0,   0,0,0,0,         0,1, 7,0, 1,'hEE,0,0,     0,0,0,       0,0,0,    0,0);

    idleInputs();
    rst_in = 1;
    rdy_in = 1;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 0;
`ifdef REGFILE_BUSY_COUNT_EN
    #1;
    checkOutput("reset.busy_count", 32'(busy_count), 32'd0);
`endif

    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Busy two registers, then reset while stalled: reset must still win
    @(negedge clk_in);
    idleInputs();
    rdy_in = 1;
    dec_ready = 1; dec_rd = 5'd5; dec_rob_id = RW'(2);
    @(negedge clk_in);
    dec_rd = 5'd7; dec_rob_id = RW'(3);
    @(negedge clk_in);
    idleInputs();
    dec_rs1 = 5'd5; dec_rs2 = 5'd7;
    #1;
    checkOutput("pre_reset.dep1_valid", 32'(dep1_valid), 32'd1);
    checkOutput("pre_reset.dep2", 32'(dep2), 32'd3);
`ifdef REGFILE_BUSY_COUNT_EN
    checkOutput("pre_reset.busy_count", 32'(busy_count), 32'd2);
`endif
    rst_in = 1;
    rdy_in = 0;
    @(negedge clk_in);
    rst_in = 0;
    rdy_in = 1;
    #1;
    checkOutput("post_reset.val1", val1, 32'd0);
    checkOutput("post_reset.dep1_valid", 32'(dep1_valid), 32'd0);
    checkOutput("post_reset.dep2_valid", 32'(dep2_valid), 32'd0);
`ifdef REGFILE_BUSY_COUNT_EN
    checkOutput("post_reset.busy_count", 32'(busy_count), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
